lisp_trace_buffer: RTL and testbench

Synthesizable on-chip trace capture unit for the Lisp core. It records per-instruction CPU state (instruction pointer, opcode, param, state, stack pointer, top of stack, memory-write flag) into a circular buffer, stops a programmable number of samples after a trigger, and offers a read-out port. It sits beside the core and taps the core's internal signals.

---
 rtl/lisp_trace_pkg.sv | 40 ++++
 rtl/lisp_trace_ram.sv | 38 +++
 rtl/lisp_trace_buffer.sv | 160 ++++++++++++++++
 tb/tb_lisp_trace_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_trace_pkg.sv
// Shared definitions for the Lisp core trace buffer: trigger modes, FSM encoding
// and the packed record layout derived from the core's field widths.
package lisp_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam logic [1:0] TRIG_IP     = 2'd0;
    localparam logic [1:0] TRIG_OPCODE = 2'd1;
    localparam logic [1:0] TRIG_MEMWR  = 2'd2;
    localparam logic [1:0] TRIG_EXT    = 2'd3;

    // Record fields from LSB upwards: ip, top_of_stack, stack_pointer, param,
    // opcode, core_state, mem_write_enable.
    typedef enum int {
        F_IP, F_TOS, F_SP, F_PARAM, F_OPCODE, F_STATE, F_MWE
    } rec_field_e;

    function automatic int rec_width(input int ipw, input int dw, input int ow, input int sw);
        return 1 + sw + ow + 3 * dw + ipw;
    endfunction

    function automatic int field_offset(input rec_field_e f, input int ipw, input int dw,
                                        input int ow, input int sw);
        case (f)
            F_IP:     return 0;
            F_TOS:    return ipw;
            F_SP:     return ipw + dw;
            F_PARAM:  return ipw + 2 * dw;
            F_OPCODE: return ipw + 3 * dw;
            F_STATE:  return ipw + 3 * dw + ow;
            default:  return ipw + 3 * dw + ow + sw;
        endcase
    endfunction

endpackage

// File: rtl/lisp_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port
// (latency 1). The read register holds its value when no read is issued.
module lisp_trace_ram #(
    parameter int DEPTH     = 256,
    parameter int REC_WIDTH = 74,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [REC_WIDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [REC_WIDTH-1:0] rdata_o
);

    logic [REC_WIDTH-1:0] mem_q [DEPTH];
    logic [REC_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lisp_trace_buffer.sv
// Trace capture unit for the Lisp core: circular record buffer with a
// programmable trigger, post-trigger sample count and a read-out port.
module lisp_trace_buffer
    import lisp_trace_pkg::*;
#(
    parameter int IP_WIDTH     = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 5,
    parameter int STATE_WIDTH  = 4,
    parameter int DEPTH        = 256,
    parameter int POST_TRIGGER = 128,
    localparam int AW          = $clog2(DEPTH),
    localparam int REC_WIDTH   = rec_width(IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [1:0]              trig_mode,
    input  logic [DATA_WIDTH-1:0]   trig_value,
    input  logic                    ext_trigger,
    input  logic                    sample_en,
    input  logic [IP_WIDTH-1:0]     ip,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   param,
    input  logic [STATE_WIDTH-1:0]  core_state,
    input  logic [DATA_WIDTH-1:0]   stack_pointer,
    input  logic [DATA_WIDTH-1:0]   top_of_stack,
    input  logic                    mem_write_enable,
    input  logic [DATA_WIDTH-1:0]   mem_addr,
    input  logic                    rd_req,
    input  logic [AW-1:0]           rd_index,
    output logic                    rd_valid,
    output logic [REC_WIDTH-1:0]    rd_data,
    output logic [1:0]              status_state,
    output logic [AW:0]             entry_count,
    output logic [AW-1:0]           trig_index
);

    localparam int OFF_IP     = field_offset(F_IP,     IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_TOS    = field_offset(F_TOS,    IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_SP     = field_offset(F_SP,     IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_PARAM  = field_offset(F_PARAM,  IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_OPCODE = field_offset(F_OPCODE, IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_STATE  = field_offset(F_STATE,  IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam int OFF_MWE    = field_offset(F_MWE,    IP_WIDTH, DATA_WIDTH, OPCODE_WIDTH, STATE_WIDTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIGGER);

    trace_state_e   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           wrapped_q, wrapped_d;
    logic [AW-1:0]  post_cnt_q, post_cnt_d;
    logic [AW-1:0]  trig_addr_q, trig_addr_d;
    logic           rd_valid_q;

    logic                 match, hit, sample_ok, we, rd_en;
    logic [AW-1:0]        oldest;
    logic [REC_WIDTH-1:0] rec;

    always_comb begin
        rec = '0;
        rec[OFF_IP     +: IP_WIDTH]     = ip;
        rec[OFF_TOS    +: DATA_WIDTH]   = top_of_stack;
        rec[OFF_SP     +: DATA_WIDTH]   = stack_pointer;
        rec[OFF_PARAM  +: DATA_WIDTH]   = param;
        rec[OFF_OPCODE +: OPCODE_WIDTH] = opcode;
        rec[OFF_STATE  +: STATE_WIDTH]  = core_state;
        rec[OFF_MWE]                    = mem_write_enable;
    end

    always_comb begin
        case (trig_mode)
            TRIG_IP:     match = (ip == trig_value[IP_WIDTH-1:0]);
            TRIG_OPCODE: match = (opcode == trig_value[OPCODE_WIDTH-1:0]);
            TRIG_MEMWR:  match = mem_write_enable && (mem_addr == trig_value);
            default:     match = ext_trigger;
        endcase
    end

    assign hit       = sample_en && match;
    assign sample_ok = sample_en && ((state_q == ST_ARMED) || (state_q == ST_POST));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        we          = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            post_cnt_d  = '0;
            trig_addr_d = '0;
        end else if (sample_ok) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == '1) begin
                wrapped_d = 1'b1;
            end
            if (state_q == ST_ARMED && hit) begin
                trig_addr_d = wr_ptr_q;
                post_cnt_d  = POST_LOAD;
                state_d     = (POST_TRIGGER == 0) ? ST_DONE : ST_POST;
            end else if (state_q == ST_POST) begin
                // The sample taking the counter to zero is the last one stored.
                post_cnt_d = post_cnt_q - 1'b1;
                if (post_cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            rd_valid_q  <= rd_en;
        end
    end

    assign oldest = wrapped_q ? wr_ptr_q : '0;
    assign rd_en  = rd_req && (state_q == ST_DONE);

    lisp_trace_ram #(
        .DEPTH     (DEPTH),
        .REC_WIDTH (REC_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (rec),
        .re_i    (rd_en),
        .raddr_i (oldest + rd_index),
        .rdata_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign status_state = state_q;
    assign entry_count  = wrapped_q ? (AW + 1)'(DEPTH) : {1'b0, wr_ptr_q};
    assign trig_index   = trig_addr_q - oldest;

endmodule

// File: tb/tb_lisp_trace_buffer.sv
// Directed bench for lisp_trace_buffer: DEPTH=16 with POST_TRIGGER=4 and POST_TRIGGER=0
// instances sharing one stimulus stream.
module tb_lisp_trace_buffer;

    localparam int RW = 74;

    logic        clk = 1'b0;
    logic        reset, arm, abort, ext_trigger, sample_en, mwe, rd_req;
    logic [1:0]  trig_mode;
    logic [15:0] trig_value, ip, param, sp, tos, mem_addr;
    logic [4:0]  opcode;
    logic [3:0]  core_state, rd_index;

    logic          a_rd_valid, b_rd_valid;
    logic [RW-1:0] a_rd_data, b_rd_data;
    logic [1:0]    a_state, b_state;
    logic [4:0]    a_count, b_count;
    logic [3:0]    a_trig, b_trig;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] exp_ip;
    } rd_vec_t;

    rd_vec_t scn1_vecs [4];

    always #5 clk = ~clk;

    lisp_trace_buffer #(.DEPTH(16), .POST_TRIGGER(4)) u_dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_mode(trig_mode),
        .trig_value(trig_value), .ext_trigger(ext_trigger), .sample_en(sample_en), .ip(ip),
        .opcode(opcode), .param(param), .core_state(core_state), .stack_pointer(sp),
        .top_of_stack(tos), .mem_write_enable(mwe), .mem_addr(mem_addr), .rd_req(rd_req),
        .rd_index(rd_index), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .status_state(a_state), .entry_count(a_count), .trig_index(a_trig)
    );

    lisp_trace_buffer #(.DEPTH(16), .POST_TRIGGER(0)) u_dut0 (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_mode(trig_mode),
        .trig_value(trig_value), .ext_trigger(ext_trigger), .sample_en(sample_en), .ip(ip),
        .opcode(opcode), .param(param), .core_state(core_state), .stack_pointer(sp),
        .top_of_stack(tos), .mem_write_enable(mwe), .mem_addr(mem_addr), .rd_req(rd_req),
        .rd_index(rd_index), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .status_state(b_state), .entry_count(b_count), .trig_index(b_trig)
    );

    // Expected record for a sample whose other fields are derived from its ip.
    function automatic logic [RW-1:0] rec_of(input logic [15:0] v, input logic w);
        logic [15:0] p, s, t;
        p = v ^ 16'hA5A5;
        s = v + 16'd100;
        t = ~v;
        return {w, v[3:0], v[4:0], p, s, t, v};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [15:0] v, input logic en, input logic w = 1'b0,
                       input logic [15:0] addr = 16'h0, input logic ext = 1'b0);
        ip          = v;
        opcode      = v[4:0];
        param       = v ^ 16'hA5A5;
        sp          = v + 16'd100;
        tos         = ~v;
        core_state  = v[3:0];
        mwe         = w;
        mem_addr    = addr;
        ext_trigger = ext;
        sample_en   = en;
        step();
        sample_en   = 1'b0;
        mwe         = 1'b0;
        ext_trigger = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_req   = 1'b1;
        rd_index = idx;
        step();
        rd_req   = 1'b0;
    endtask

    task automatic run_scn1(input string tag);
        trig_mode  = 2'd0;
        trig_value = 16'd16;
        do_arm();
        check({tag, " armed"}, 128'(a_state), 128'd1);
        for (int v = 0; v <= 23; v++) begin
            smp(16'(v), 1'b1);
            if (v == 16) check({tag, " post after trigger"}, 128'(a_state), 128'd2);
            if (v == 19) check({tag, " still post"}, 128'(a_state), 128'd2);
            if (v == 20) check({tag, " done"}, 128'(a_state), 128'd3);
        end
        check({tag, " entry_count"}, 128'(a_count), 128'd16);
        check({tag, " trig_index"}, 128'(a_trig), 128'd11);
        for (int i = 0; i < 4; i++) begin
            rd(scn1_vecs[i].idx);
            check({tag, " rd_valid"}, 128'(a_rd_valid), 128'd1);
            check({tag, " rd_data"}, 128'(a_rd_data), 128'(rec_of(scn1_vecs[i].exp_ip, 1'b0)));
        end
        step();
        check({tag, " rd_valid drop"}, 128'(a_rd_valid), 128'd0);
    endtask

    initial begin
        scn1_vecs[0] = '{idx: 4'd0,  exp_ip: 16'd5};
        scn1_vecs[1] = '{idx: 4'd15, exp_ip: 16'd20};
        scn1_vecs[2] = '{idx: 4'd11, exp_ip: 16'd16};
        scn1_vecs[3] = '{idx: 4'd1,  exp_ip: 16'd6};

        reset = 1'b1; arm = 1'b0; abort = 1'b0; ext_trigger = 1'b0; sample_en = 1'b0;
        mwe = 1'b0; rd_req = 1'b0; trig_mode = 2'd0; trig_value = '0; ip = '0; param = '0;
        sp = '0; tos = '0; mem_addr = '0; opcode = '0; core_state = '0; rd_index = '0;
        step();
        step();
        reset = 1'b0;
        check("reset state", 128'(a_state), 128'd0);
        check("reset entry_count", 128'(a_count), 128'd0);
        check("reset trig_index", 128'(a_trig), 128'd0);
        check("reset rd_valid", 128'(a_rd_valid), 128'd0);
        check("reset rd_data", 128'(a_rd_data), 128'd0);

        // Wrapping capture with trigger late in the stream.
        run_scn1("scn1");

        // Early trigger, no wrap.
        trig_value = 16'd2;
        do_arm();
        for (int v = 0; v <= 6; v++) smp(16'(v), 1'b1);
        check("scn2 done", 128'(a_state), 128'd3);
        check("scn2 entry_count", 128'(a_count), 128'd7);
        check("scn2 trig_index", 128'(a_trig), 128'd2);
        rd(4'd0);
        check("scn2 idx0", 128'(a_rd_data), 128'(rec_of(16'd0, 1'b0)));

        // Disabled cycles neither trigger nor write; ip=16 only appears disabled.
        trig_value = 16'd16;
        do_arm();
        for (int v = 0; v <= 17; v++) smp(16'(v), 1'(v % 2));
        check("scn3 no trigger", 128'(a_state), 128'd1);
        check("scn3 entry_count", 128'(a_count), 128'd9);
        trig_mode = 2'd3;
        smp(16'd18, 1'b0, 1'b0, 16'h0, 1'b1);
        check("scn3 ext disabled", 128'(a_state), 128'd1);
        smp(16'd19, 1'b1, 1'b0, 16'h0, 1'b1);
        check("scn3 ext hit", 128'(a_state), 128'd2);
        for (int v = 21; v <= 27; v += 2) smp(16'(v), 1'b1);
        check("scn3 done", 128'(a_state), 128'd3);
        check("scn3 entry_count", 128'(a_count), 128'd14);
        check("scn3 trig_index", 128'(a_trig), 128'd9);
        rd(4'd7);
        check("scn3 idx7", 128'(a_rd_data), 128'(rec_of(16'd15, 1'b0)));
        rd(4'd8);
        check("scn3 idx8", 128'(a_rd_data), 128'(rec_of(16'd17, 1'b0)));

        // Memory-write address trigger.
        trig_mode  = 2'd2;
        trig_value = 16'h03FF;
        do_arm();
        smp(16'd40, 1'b1, 1'b1, 16'h03FE);
        check("scn4 near addr", 128'(a_state), 128'd1);
        smp(16'd41, 1'b1, 1'b0, 16'h03FF);
        check("scn4 no write", 128'(a_state), 128'd1);
        smp(16'd42, 1'b1, 1'b1, 16'h03FF);
        check("scn4 hit", 128'(a_state), 128'd2);
        for (int v = 43; v <= 46; v++) smp(16'(v), 1'b1);
        check("scn4 done", 128'(a_state), 128'd3);
        check("scn4 trig_index", 128'(a_trig), 128'd2);
        check("scn4 b entry_count", 128'(b_count), 128'd3);
        rd(4'd2);
        check("scn4 trig record", 128'(a_rd_data), 128'(rec_of(16'd42, 1'b1)));
        check("scn4 b trig record", 128'(b_rd_data), 128'(rec_of(16'd42, 1'b1)));

        // POST_TRIGGER=0 instance, opcode trigger; reads outside DONE are ignored.
        trig_mode  = 2'd1;
        trig_value = 16'h0005;
        do_arm();
        rd(4'd3);
        check("scn5 armed rd_valid", 128'(b_rd_valid), 128'd0);
        check("scn5 armed rd_data held", 128'(b_rd_data), 128'(rec_of(16'd42, 1'b1)));
        check("scn5 a armed rd_valid", 128'(a_rd_valid), 128'd0);
        for (int v = 0; v <= 4; v++) smp(16'(v), 1'b1);
        check("scn5 before hit", 128'(b_state), 128'd1);
        smp(16'd5, 1'b1);
        check("scn5 done", 128'(b_state), 128'd3);
        check("scn5 entry_count", 128'(b_count), 128'd6);
        check("scn5 trig_index", 128'(b_trig), 128'd5);
        smp(16'd6, 1'b1);
        check("scn5 no write in done", 128'(b_count), 128'd6);
        rd(4'd3);
        check("scn5 rd_valid", 128'(b_rd_valid), 128'd1);
        check("scn5 rd_data", 128'(b_rd_data), 128'(rec_of(16'd3, 1'b0)));
        step();
        check("scn5 rd_valid drop", 128'(b_rd_valid), 128'd0);

        // Reset mid-POST, re-run, then abort behaviour.
        check("scn6 in post", 128'(a_state), 128'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("scn6 reset state", 128'(a_state), 128'd0);
        check("scn6 reset count", 128'(a_count), 128'd0);
        run_scn1("scn6 rerun");

        trig_value = 16'd100;
        arm = 1'b1;
        smp(16'd0, 1'b1);
        arm = 1'b0;
        check("scn6 arm-cycle sample dropped", 128'(a_count), 128'd0);
        for (int v = 1; v <= 3; v++) smp(16'(v), 1'b1);
        check("scn6 armed count", 128'(a_count), 128'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("scn6 abort idle", 128'(a_state), 128'd0);
        smp(16'd4, 1'b1);
        check("scn6 idle no write", 128'(a_count), 128'd3);
        do_arm();
        abort = 1'b1;
        arm   = 1'b1;
        step();
        abort = 1'b0;
        arm   = 1'b0;
        check("scn6 abort beats arm", 128'(a_state), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
